// File: rtl/scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scoreboard_pkg: shared sizing and counter helpers for scoreboard_hist |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package scoreboard_pkg;

  // Accuracy spans 0..width, so it needs one more code than width.
  function automatic int acc_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int minacc_reset(input int width);
    return width;
  endfunction

  // Counters stick at all-ones of their own width instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lzc: combinational leading-zero count over exactly WIDTH bits         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lzc
  import scoreboard_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int ACC_W = acc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [ACC_W-1:0] o_count
);

  logic w_found;

  always_comb begin
    o_count = ACC_W'(WIDTH);
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_count = ACC_W'(WIDTH - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/scoreboard_hist.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scoreboard_hist: 3-stage diff scoreboard with saturating counters,    |
// | min/max accuracy, accuracy histogram and sticky first-error capture.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scoreboard_hist
  import scoreboard_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTR_W = 32,
  localparam int ACC_W = acc_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_freeze,
  input  logic             i_clear,
  input  logic             i_mon_ready,
  input  logic [WIDTH-1:0] i_diff,
  input  logic             i_hist_rd,
  input  logic [ACC_W-1:0] i_hist_addr,
  output logic [CTR_W-1:0] o_data_ctr,
  output logic [CTR_W-1:0] o_error_ctr,
  output logic [ACC_W-1:0] o_maxacc,
  output logic [ACC_W-1:0] o_minacc,
  output logic [CTR_W-1:0] o_hist_data,
  output logic             o_hist_valid,
  output logic             o_first_err_valid,
  output logic [CTR_W-1:0] o_first_err_idx,
  output logic [WIDTH-1:0] o_first_err_diff
);

  localparam logic [ACC_W-1:0] c_minacc_rst = ACC_W'(minacc_reset(WIDTH));

  logic             w_accept;
  logic [ACC_W-1:0] w_acc;
  logic [CTR_W-1:0] w_rd_bin;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_diff;
  logic             r_s2_valid;
  logic             r_s2_err;
  logic [ACC_W-1:0] r_s2_acc;
  logic [WIDTH-1:0] r_s2_diff;

  logic [CTR_W-1:0] r_data_ctr;
  logic [CTR_W-1:0] r_error_ctr;
  logic [ACC_W-1:0] r_maxacc;
  logic [ACC_W-1:0] r_minacc;
  logic [CTR_W-1:0] r_hist [0:WIDTH];
  logic             r_first_err_valid;
  logic [CTR_W-1:0] r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_diff;
  logic             r_hist_valid;
  logic [CTR_W-1:0] r_hist_data;

  assign w_accept = i_mon_ready && !i_freeze;

  lzc #(.WIDTH(WIDTH)) u_lzc (
    .i_data  (r_s1_diff),
    .o_count (w_acc)
  );

  // Pipeline stages 1 and 2; clear kills anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s2_acc   <= '0;
      r_s2_diff  <= '0;
    end else if (i_clear) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s2_acc   <= '0;
      r_s2_diff  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_diff  <= i_diff;
      r_s2_valid <= r_s1_valid;
      r_s2_err   <= |r_s1_diff;
      r_s2_acc   <= w_acc;
      r_s2_diff  <= r_s1_diff;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_ctr        <= '0;
      r_error_ctr       <= '0;
      r_maxacc          <= '0;
      r_minacc          <= c_minacc_rst;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_first_err_diff  <= '0;
      for (int b = 0; b <= WIDTH; b++) r_hist[b] <= '0;
    end else if (i_clear) begin
      r_data_ctr        <= '0;
      r_error_ctr       <= '0;
      r_maxacc          <= '0;
      r_minacc          <= c_minacc_rst;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_first_err_diff  <= '0;
      for (int b = 0; b <= WIDTH; b++) r_hist[b] <= '0;
    end else if (r_s2_valid) begin
      r_data_ctr <= CTR_W'(sat_inc(64'(r_data_ctr), CTR_W));
      if (r_s2_err) r_error_ctr <= CTR_W'(sat_inc(64'(r_error_ctr), CTR_W));
      for (int b = 0; b <= WIDTH; b++) begin
        if (r_s2_acc == ACC_W'(b)) r_hist[b] <= CTR_W'(sat_inc(64'(r_hist[b]), CTR_W));
      end
      if (r_s2_acc > r_maxacc) r_maxacc <= r_s2_acc;
      if (r_s2_acc < r_minacc) r_minacc <= r_s2_acc;
      // Index is the pre-increment sample count, i.e. 0-based.
      if (!r_first_err_valid && r_s2_err) begin
        r_first_err_valid <= 1'b1;
        r_first_err_idx   <= r_data_ctr;
        r_first_err_diff  <= r_s2_diff;
      end
    end
  end

  // Bin mux; addresses beyond WIDTH match no bin and read as zero.
  always_comb begin
    w_rd_bin = '0;
    for (int b = 0; b <= WIDTH; b++) begin
      if (i_hist_addr == ACC_W'(b)) w_rd_bin = r_hist[b];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist_valid <= 1'b0;
      r_hist_data  <= '0;
    end else begin
      r_hist_valid <= i_hist_rd;
      r_hist_data  <= (i_hist_rd && !i_clear) ? w_rd_bin : '0;
    end
  end

  assign o_data_ctr        = r_data_ctr;
  assign o_error_ctr       = r_error_ctr;
  assign o_maxacc          = r_maxacc;
  assign o_minacc          = r_minacc;
  assign o_hist_data       = r_hist_data;
  assign o_hist_valid      = r_hist_valid;
  assign o_first_err_valid = r_first_err_valid;
  assign o_first_err_idx   = r_first_err_idx;
  assign o_first_err_diff  = r_first_err_diff;

endmodule
`default_nettype wire

// File: doc/scoreboard_hist.md
# scoreboard_hist

Parametrised, pipelined successor to the arithmetic-testbench scoreboard. It consumes the monitor's per-sample difference word (DUT result XOR golden result) and keeps saturating data and error counters. It also derives per-sample accuracy (leading matching bits) and tracks min/max accuracy, a full accuracy histogram and a sticky first-error capture. It sits between the monitor and the HPS register map; the HPS reads statistics and histogram bins through a one-cycle read port.

## Interface
- WIDTH, 32: diff width, legal 1..64; accuracy range 0..WIDTH.
- CTR_W, 32: width of data, error and histogram counters.
- ACC_W, $clog2(WIDTH+1): accuracy/bin-address width (derived, not overridden).
- clk  in  1  sole clock; everything on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_freeze  in  1  HPS freeze; blocks new samples from entering the pipeline.
- i_clear  in  1  synchronous clear of all statistics and pipeline.
- i_mon_ready  in  1  monitor sample valid.
- i_diff  in  WIDTH  difference word; zero means exact match.
- i_hist_rd  in  1  histogram read request.
- i_hist_addr  in  ACC_W  bin index (accuracy value).
- o_data_ctr / o_error_ctr  out  CTR_W  samples counted / samples with nonzero diff.
- o_maxacc / o_minacc  out  ACC_W  best / worst accuracy seen.
- o_hist_data  out  CTR_W  read data; o_hist_valid  out  1  read data valid.
- o_first_err_valid  out  1  sticky; o_first_err_idx  out  CTR_W  sample index of first error; o_first_err_diff  out  WIDTH  its diff.

## Operation
- Accept = i_mon_ready && !i_freeze; only accepted samples affect statistics.
- Accuracy = count of leading zeros of i_diff over exactly WIDTH bits, MSB first; diff==0 gives WIDTH. No padding to 32 bits.
- Error = |i_diff.
- Stage 1 registers accept/diff; stage 2 registers accuracy and error flag; stage 3 updates all statistics.
- Stage 3: data_ctr+1; error_ctr+1 if error; hist[acc]+1; maxacc/minacc compare against acc.
- All counters saturate at all-ones; no wrap. The sample is still used for min/max and first-error.
- First error: if !first_err_valid and the sample is an error, capture idx = data_ctr value before increment (0-based, saturated value if saturated) and diff; set valid. Held until clear or reset.
- Reset values: all counters 0, hist bins 0, maxacc 0, minacc WIDTH, first_err_* 0, o_hist_valid 0, o_hist_data 0, pipeline valids 0.
- i_clear: same values as reset, applied at the next edge. It also kills in-flight pipeline samples. Clear wins over a simultaneous stage-3 update.
- Histogram read: i_hist_rd at edge n gives o_hist_data = hist[addr] and o_hist_valid = 1 after edge n, held for one cycle. addr > WIDTH reads 0. A read and an update of the same bin in the same cycle returns the pre-update value. A read concurrent with i_clear returns 0.
- Freeze only gates entry. Samples already in flight complete, so statistics may move for 2 cycles after freeze rises.

## Timing
- Sample accepted at edge n is visible on all statistic outputs after edge n+2. Latency 3 edges including input register; throughput 1 sample/clk.
- Statistic outputs are registered; no combinational input-to-output paths.
- reset_n deassertion is synchronised externally; assertion mid-operation immediately forces reset values, and in-flight samples are lost.

## Structure
- Shared package scoreboard_pkg: function/constant for ACC_W derivation, reset constant for minacc, saturating-increment function.
- Sub-module lzc #(WIDTH): combinational leading-zero counter (tree or priority loop) returning ACC_W bits, WIDTH on all-zero; instantiated in stage 2.
- Histogram as register array [0:WIDTH] of CTR_W.

## Test plan
- Reset (WIDTH=8): pulse reset_n low mid-stream -> all counters 0, minacc 8, maxacc 0, first_err_valid 0, o_hist_valid 0, asynchronously.
- Diffs 0x00, 0x01, 0x80 on consecutive cycles -> 3 edges after last: data 3, error 2, hist[8]=1, hist[7]=1, hist[0]=1, max 8, min 0, first_err idx 1, diff 0x01.
- Freeze: 4 samples of 0x10, freeze high for samples 2-3 -> data 2, hist[3]=2; freeze rising with 2 in flight still counts them.
- CTR_W=4: 20 samples of 0xFF -> error_ctr 15, data_ctr 15, hist[0] 15, no wrap.
- i_clear on same cycle a sample reaches stage 3, plus concurrent hist read of that bin -> all statistics at reset values, read returns 0, next sample counts as index 0.
- WIDTH=5, diff 0b00001 -> accuracy 4; read addr 6 -> 0 with o_hist_valid 1.
